// File: rtl/egress_arbiter_pkg.sv
// Shared definitions for the egress arbiter: FSM encoding and default widths.
package egress_arbiter_pkg;
   localparam int DATA_WIDTH_DEF = 6;
   localparam int DEST_BIT_DEF   = 4;
   localparam int CNT_WIDTH_DEF  = 5;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2
   } egress_state_t;
endpackage

// File: rtl/egress_arbiter_counter.sv
// Wrap-around push counter for one destination FIFO.
module egress_arbiter_counter #(
   parameter int cnt_width = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   output logic [cnt_width-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (inc)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/egress_arbiter.sv
// Drains VC0/VC1 with VC0 strict priority and routes each word to D0 or D1.
//
// state  | meaning
// INIT   | one cycle after reset release, no pops
// IDLE   | nothing in flight, both VC FIFOs empty (idle=1)
// ACTIVE | VC data pending or words in the pipeline
module egress_arbiter
   import egress_arbiter_pkg::*;
#(
   parameter int data_width = DATA_WIDTH_DEF,
   parameter int DEST_BIT   = DEST_BIT_DEF,
   parameter int cnt_width  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  empty_fifo_VC0,
   input  logic                  empty_fifo_VC1,
   input  logic [data_width-1:0] data_out_VC0,
   input  logic [data_width-1:0] data_out_VC1,
   input  logic                  almost_full_fifo_D0,
   input  logic                  almost_full_fifo_D1,
   input  logic                  req,
   input  logic                  idx,
   output logic                  pop_VC0_fifo,
   output logic                  pop_VC1_fifo,
   output logic                  push_D0,
   output logic                  push_D1,
   output logic [data_width-1:0] data_out_D,
   output logic                  idle,
   output logic [cnt_width-1:0]  data_out_cnt,
   output logic                  valid_cnt
);

   egress_state_t         state, state_nxt;
   logic                  stall;
   logic                  pop_ok;
   logic                  valid1;
   logic                  src1;
   logic [data_width-1:0] word_sel;
   logic [cnt_width-1:0]  cnt_D0, cnt_D1;

   // Destination is unknown until the word is read, so either almost_full stalls both VCs.
   always_comb begin
      stall        = almost_full_fifo_D0 | almost_full_fifo_D1;
      pop_ok       = !reset && (state != ST_INIT) && !stall;
      pop_VC0_fifo = pop_ok && !empty_fifo_VC0;
      pop_VC1_fifo = pop_ok && empty_fifo_VC0 && !empty_fifo_VC1;
      word_sel     = src1 ? data_out_VC1 : data_out_VC0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_INIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      idle      = 1'b0;
      case (state)
         ST_INIT:   state_nxt = ST_IDLE;
         ST_IDLE: begin
            idle = 1'b1;
            if (!empty_fifo_VC0 || !empty_fifo_VC1)
               state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (empty_fifo_VC0 && empty_fifo_VC1 && !valid1 && !push_D0 && !push_D1)
               state_nxt = ST_IDLE;
         end
         default:   state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid1     <= 1'b0;
         src1       <= 1'b0;
         push_D0    <= 1'b0;
         push_D1    <= 1'b0;
         data_out_D <= '0;
      end else begin
         valid1  <= pop_VC0_fifo | pop_VC1_fifo;
         src1    <= pop_VC1_fifo;
         push_D0 <= valid1 & !word_sel[DEST_BIT];
         push_D1 <= valid1 & word_sel[DEST_BIT];
         if (valid1)
            data_out_D <= word_sel;
      end
   end

   egress_arbiter_counter #(.cnt_width(cnt_width)) u_cnt_D0 (
      .clk   (clk),
      .reset (reset),
      .inc   (push_D0),
      .count (cnt_D0)
   );

   egress_arbiter_counter #(.cnt_width(cnt_width)) u_cnt_D1 (
      .clk   (clk),
      .reset (reset),
      .inc   (push_D1),
      .count (cnt_D1)
   );

   // Sampling the counters at the same edge they increment returns the pre-increment value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out_cnt <= '0;
         valid_cnt    <= 1'b0;
      end else if (req) begin
         data_out_cnt <= idx ? cnt_D1 : cnt_D0;
         valid_cnt    <= 1'b1;
      end else begin
         valid_cnt    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_egress_arbiter.sv
// Scoreboard bench for egress_arbiter: bench-side VC FIFO models feed the DUT, pops enqueue expected pushes.
module tb_egress_arbiter;
   localparam int DW = 6;
   localparam int DB = 4;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          empty_fifo_VC0 = 1'b1, empty_fifo_VC1 = 1'b1;
   logic [DW-1:0] data_out_VC0 = '0, data_out_VC1 = '0;
   logic          almost_full_fifo_D0 = 1'b0, almost_full_fifo_D1 = 1'b0;
   logic          req = 1'b0, idx = 1'b0;
   logic          pop_VC0_fifo, pop_VC1_fifo, push_D0, push_D1, idle, valid_cnt;
   logic [DW-1:0] data_out_D;
   logic [CW-1:0] data_out_cnt;

   egress_arbiter dut (
      .clk                 (clk),
      .reset               (reset),
      .empty_fifo_VC0      (empty_fifo_VC0),
      .empty_fifo_VC1      (empty_fifo_VC1),
      .data_out_VC0        (data_out_VC0),
      .data_out_VC1        (data_out_VC1),
      .almost_full_fifo_D0 (almost_full_fifo_D0),
      .almost_full_fifo_D1 (almost_full_fifo_D1),
      .req                 (req),
      .idx                 (idx),
      .pop_VC0_fifo        (pop_VC0_fifo),
      .pop_VC1_fifo        (pop_VC1_fifo),
      .push_D0             (push_D0),
      .push_D1             (push_D1),
      .data_out_D          (data_out_D),
      .idle                (idle),
      .data_out_cnt        (data_out_cnt),
      .valid_cnt           (valid_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          dest;
      int            cyc;
   } sb_t;

   logic [DW-1:0] q0[$], q1[$];
   sb_t           sb[$];
   int            n_checks = 0, n_err = 0;
   int            cyc = 0, push_total = 0;
   logic          in_init = 1'b1;
   logic [CW-1:0] cm0 = '0, cm1 = '0;
   logic          pend0 = 1'b0, pend1 = 1'b0;
   logic [DW-1:0] last_word = '0;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: check pops before the edge, feed the FIFO models after it, check pushes at negedge.
   task automatic step();
      logic p0, p1, ep0, ep1, st;
      sb_t  ent;
      empty_fifo_VC0 = (q0.size() == 0);
      empty_fifo_VC1 = (q1.size() == 0);
      if (reset) in_init = 1'b1;
      #1;
      st  = almost_full_fifo_D0 | almost_full_fifo_D1;
      ep0 = !reset && !in_init && !empty_fifo_VC0 && !st;
      ep1 = !reset && !in_init && empty_fifo_VC0 && !empty_fifo_VC1 && !st;
      chk("pop_VC0", pop_VC0_fifo, ep0);
      chk("pop_VC1", pop_VC1_fifo, ep1);
      p0 = pop_VC0_fifo;
      p1 = pop_VC1_fifo;
      if (p0 && q0.size() > 0) begin
         ent.data = q0[0]; ent.dest = q0[0][DB]; ent.cyc = cyc; sb.push_back(ent);
      end else if (p1 && q1.size() > 0) begin
         ent.data = q1[0]; ent.dest = q1[0][DB]; ent.cyc = cyc; sb.push_back(ent);
      end
      @(posedge clk);
      #1;
      cyc++;
      in_init = reset;
      if (pend0) cm0 = cm0 + 1'b1;
      if (pend1) cm1 = cm1 + 1'b1;
      pend0 = 1'b0;
      pend1 = 1'b0;
      if (p0 && q0.size() > 0) data_out_VC0 = q0.pop_front();
      if (p1 && q1.size() > 0) data_out_VC1 = q1.pop_front();
      empty_fifo_VC0 = (q0.size() == 0);
      empty_fifo_VC1 = (q1.size() == 0);
      @(negedge clk);
      if (push_D0 || push_D1) begin
         push_total++;
         chk("push_expected", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            ent = sb.pop_front();
            chk("push_data", data_out_D, ent.data);
            chk("push_D0", push_D0, !ent.dest);
            chk("push_D1", push_D1, ent.dest);
            chk("push_latency", cyc - ent.cyc, 2);
            last_word = ent.data;
            pend0 = push_D0;
            pend1 = push_D1;
         end
      end else if (sb.size() != 0 && (cyc - sb[0].cyc) >= 2) begin
         chk("push_missing", push_D0 | push_D1, 1);
         void'(sb.pop_front());
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic readout(input logic sel, input int unsigned exp);
      req = 1'b1;
      idx = sel;
      step();
      req = 1'b0;
      chk("rd_valid", valid_cnt, 1);
      chk("rd_value", data_out_cnt, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      q0.delete();
      q1.delete();
      sb.delete();
      cm0 = '0; cm1 = '0;
      pend0 = 1'b0; pend1 = 1'b0;
      in_init = 1'b1;
      #1;
      chk("rst_pop_VC0", pop_VC0_fifo, 0);
      chk("rst_pop_VC1", pop_VC1_fifo, 0);
      chk("rst_push_D0", push_D0, 0);
      chk("rst_push_D1", push_D1, 0);
      chk("rst_data_out_D", data_out_D, 0);
      chk("rst_idle", idle, 0);
      chk("rst_valid_cnt", valid_cnt, 0);
      chk("rst_data_out_cnt", data_out_cnt, 0);
      run(3);
      reset = 1'b0;
      #1;
      chk("init_idle", idle, 0);
      step();
      chk("post_init_idle", idle, 1);
   endtask

   initial begin
      int unsigned infl;
      int          pt0;

      // Reset with both VC FIFOs empty, counters read back as zero.
      do_reset();
      run(2);
      readout(1'b0, 0);
      readout(1'b1, 0);

      // Priority order VC0, VC0, VC1 and routing by bit 4.
      q0.push_back(6'h05);
      q0.push_back(6'h12);
      q1.push_back(6'h31);
      step();
      chk("active_idle", idle, 0);
      run(8);
      chk("drained_idle", idle, 1);
      chk("hold_data", data_out_D, 6'h31);
      readout(1'b0, cm0);
      readout(1'b1, cm1);
      chk("cnt_D1_after_burst", data_out_cnt, 2);

      // Backpressure mid-burst: pops stop immediately, in-flight words still land.
      foreach (q0[i]) q0.delete(i);
      q0 = '{6'h01, 6'h13, 6'h05, 6'h17, 6'h09, 6'h1B};
      q1 = '{6'h22, 6'h30, 6'h2F};
      run(3);
      almost_full_fifo_D1 = 1'b1;
      infl = sb.size();
      pt0  = push_total;
      run(4);
      chk("stall_pushes", push_total - pt0, infl);
      chk("stall_sb_drained", sb.size(), 0);
      almost_full_fifo_D1 = 1'b0;
      #1;
      chk("resume_pop", pop_VC0_fifo | pop_VC1_fifo, 1);
      run(12);
      chk("stall_drained_idle", idle, 1);

      // Reset one cycle after a pop drops the in-flight word.
      q0 = '{6'h07, 6'h08};
      step();
      do_reset();
      run(4);
      readout(1'b0, 0);

      // 33 D0 pushes wrap the 5-bit counter to 1.
      for (int i = 0; i < 33; i++) q0.push_back(6'(i % 16));
      run(40);
      readout(1'b0, cm0);
      chk("cnt_D0_wrap", data_out_cnt, 1);

      // Readout coinciding with a D1 push returns the pre-increment count.
      q1 = '{6'h10, 6'h11, 6'h12};
      run(8);
      q0.push_back(6'h1C);
      run(2);
      chk("coincide_push_D1", push_D1, 1);
      req = 1'b1;
      idx = 1'b1;
      step();
      chk("rd_pre_valid", valid_cnt, 1);
      chk("rd_pre_inc", data_out_cnt, 3);
      step();
      req = 1'b0;
      chk("rd_post_inc", data_out_cnt, 4);
      step();
      chk("rd_valid_drop", valid_cnt, 0);
      chk("rd_hold", data_out_cnt, 4);
      run(4);
      chk("final_idle", idle, 1);
      chk("final_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
